unified_mem_arbiter: RTL

- Shares one single-port, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store).
- Sequences each access as request, grant, memory handshake, then a one-cycle ready pulse back to the requester.
- Produces per-stage stall signals that the pipeline uses to freeze the PC, IF/ID and downstream registers while an access is pending.
- Arbitration: MEM has priority by default; IF gets alternating fairness under sustained contention.

---
 rtl/unified_mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the IF and MEM
// pipeline stages; each access is granted, issued as a one-cycle strobe and closed by ram_valid.
module unified_mem_arbiter #(
   parameter int WORDLENGTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [WORDLENGTH-1:0] if_rdata,
   output logic                  if_ready,
   output logic                  if_stall,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [WORDLENGTH-1:0] mem_wdata,
   output logic [WORDLENGTH-1:0] mem_rdata,
   output logic                  mem_ready,
   output logic                  mem_stall,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [WORDLENGTH-1:0] ram_wdata,
   input  logic [WORDLENGTH-1:0] ram_rdata,
   input  logic                  ram_valid
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } state_t;

   state_t state;
   logic   last_was_mem;

   // A request whose ready is pulsing this cycle has just been served and must not be re-granted.
   logic if_pending;
   logic mem_pending;
   logic grant_mem;
   logic grant_if;
   logic valid_seen;

   assign if_pending  = if_req & ~if_ready;
   assign mem_pending = mem_req & ~mem_ready;
   assign grant_mem   = mem_pending & (~if_pending | ~last_was_mem);
   assign grant_if    = if_pending & ~grant_mem;

   // ram_en marks the first busy cycle; a completion strobe there is too early to be real.
   assign valid_seen  = ram_valid & ~ram_en;

   assign if_stall  = if_req & ~if_ready;
   assign mem_stall = mem_req & ~mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_was_mem <= 1'b0;
         if_rdata     <= '0;
         mem_rdata    <= '0;
         if_ready     <= 1'b0;
         mem_ready    <= 1'b0;
         ram_en       <= 1'b0;
         ram_we       <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
      end else begin
         ram_en    <= 1'b0;
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_mem) begin
                  state     <= BUSY_MEM;
                  ram_en    <= 1'b1;
                  ram_we    <= mem_we;
                  ram_addr  <= mem_addr;
                  ram_wdata <= mem_wdata;
               end else if (grant_if) begin
                  state     <= BUSY_IF;
                  ram_en    <= 1'b1;
                  ram_we    <= 1'b0;
                  ram_addr  <= if_addr;
                  ram_wdata <= '0;
               end
            end
            BUSY_IF: begin
               if (valid_seen) begin
                  state        <= IDLE;
                  if_ready     <= 1'b1;
                  if_rdata     <= ram_rdata;
                  last_was_mem <= 1'b0;
               end
            end
            BUSY_MEM: begin
               if (valid_seen) begin
                  state        <= IDLE;
                  mem_ready    <= 1'b1;
                  last_was_mem <= 1'b1;
                  // Stores leave the previously loaded word visible.
                  if (!ram_we) begin
                     mem_rdata <= ram_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
